// File: rtl/carousel_rotate_if.sv
// carousel_rotate_if: per-channel input and per-lane output valid/ready bundle for carousel_rotate.
interface carousel_rotate_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       data_in_valid;
    logic [CHANNELS-1:0]       data_in_ready;
    logic [CHANNELS*WIDTH-1:0] data_out;
    logic [CHANNELS-1:0]       data_out_valid;
    logic [CHANNELS-1:0]       data_out_ready;
    modport master (output data_in, data_in_valid, data_out_ready,
                    input  data_in_ready, data_out, data_out_valid);
    modport slave  (input  data_in, data_in_valid, data_out_ready,
                    output data_in_ready, data_out, data_out_valid);
endinterface

// File: rtl/carousel_rotate.sv
// carousel_rotate: per-channel FIFOs feeding rotated output lanes, one round when all FIFOs hold data.
// Optional CAROUSEL_ROUND_COUNT_EN adds a 16-bit wrapping round counter output.
module carousel_rotate #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 2,
    parameter int ROT_STEP = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    carousel_rotate_if.slave            bus,
    output logic [$clog2(CHANNELS)-1:0] rot_offset
`ifdef CAROUSEL_ROUND_COUNT_EN
    ,
    output logic [15:0]                 round_count
`endif
);
    localparam int RW = $clog2(CHANNELS);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem_q [CHANNELS][DEPTH];
    logic [PW-1:0]       rd_q [CHANNELS], rd_d [CHANNELS];
    logic [PW-1:0]       wr_q [CHANNELS], wr_d [CHANNELS];
    logic [CW-1:0]       cnt_q [CHANNELS], cnt_d [CHANNELS];
    logic [WIDTH-1:0]    out_q [CHANNELS], out_d [CHANNELS];
    logic [CHANNELS-1:0] ov_q, ov_d, push, nonempty, lane_free;
    logic [RW-1:0]       rot_q, rot_d, sel;
    logic [RW:0]         rot_sum, idx;
    logic                fire;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.data_in_ready[i] = rst && cnt_q[i] != CW'(DEPTH);
            nonempty[i]          = cnt_q[i] != '0;
            lane_free[i]         = !ov_q[i] || bus.data_out_ready[i];
            push[i]              = bus.data_in_valid[i] && bus.data_in_ready[i];
        end
        fire = &nonempty && &lane_free;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_d[i]  = fire ? nxt(rd_q[i]) : rd_q[i];
            wr_d[i]  = push[i] ? nxt(wr_q[i]) : wr_q[i];
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(fire);
            // lane i takes the head of channel (i + rot_offset) mod CHANNELS
            idx      = (RW+1)'(i) + {1'b0, rot_q};
            sel      = idx >= (RW+1)'(CHANNELS) ? RW'(idx - (RW+1)'(CHANNELS)) : RW'(idx);
            out_d[i] = fire ? mem_q[sel][rd_q[sel]] : out_q[i];
            ov_d[i]  = fire || (ov_q[i] && !bus.data_out_ready[i]);
            bus.data_out[i*WIDTH +: WIDTH] = out_q[i];
        end
        rot_sum = {1'b0, rot_q} + (RW+1)'(ROT_STEP);
        rot_d   = !fire ? rot_q :
                  rot_sum >= (RW+1)'(CHANNELS) ? RW'(rot_sum - (RW+1)'(CHANNELS)) : RW'(rot_sum);
        bus.data_out_valid = ov_q;
        rot_offset         = rot_q;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= bus.data_in[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
                out_q[i] <= '0;
            end
            ov_q  <= '0;
            rot_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            rot_q <= rot_d;
        end
    end

`ifdef CAROUSEL_ROUND_COUNT_EN
    logic [15:0] rc_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rc_q <= '0;
        else if (fire) rc_q <= rc_q + 16'd1;
    end
    assign round_count = rc_q;
`endif
endmodule

// File: tb/tb_carousel_rotate.sv
// tb_carousel_rotate: table vectors plus a FIFO/rotation scoreboard checked around every clock edge.
module tb_carousel_rotate;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] rot;
`ifdef CAROUSEL_ROUND_COUNT_EN
    logic [15:0] rc;
`endif
    int errors = 0;
    int checks = 0;

    carousel_rotate_if #(.WIDTH(8), .CHANNELS(3)) bus ();

    carousel_rotate #(.WIDTH(8), .CHANNELS(3), .DEPTH(2), .ROT_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rot_offset (rot)
`ifdef CAROUSEL_ROUND_COUNT_EN
        ,
        .round_count(rc)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  mq  [3][$];
    logic [7:0]  exq [3][$];
    logic [2:0]  mov;
    int          mrot;
    logic [15:0] mrc;

    typedef struct {
        logic [2:0]  vin;
        logic [23:0] d;
        logic [2:0]  ordy;
        logic [2:0]  ov;
        logic [1:0]  rot;
        logic [23:0] out;
    } vec_t;
    vec_t tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            exq[i].delete();
        end
        mov  = '0;
        mrot = 0;
        mrc  = '0;
    endtask

    // Drive one cycle, check pre-edge outputs against the model, predict the edge, then step.
    task automatic cycle(input logic [2:0] vin, input logic [23:0] d, input logic [2:0] ordy);
        logic [2:0] acc;
        logic       fire;
        bus.data_in        = d;
        bus.data_in_valid  = vin;
        bus.data_out_ready = ordy;
        #1;
        fire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ready%0d", i), {31'd0, bus.data_in_ready[i]}, {31'd0, mq[i].size() < 2});
            chk($sformatf("valid%0d", i), {31'd0, bus.data_out_valid[i]}, {31'd0, mov[i]});
            if (mov[i]) begin
                if (exq[i].size() == 0) chk($sformatf("sb_lane%0d", i), 32'd0, 32'd1);
                else chk($sformatf("data%0d", i), {24'd0, bus.data_out[i*8 +: 8]}, {24'd0, exq[i][0]});
            end
            acc[i] = vin[i] && mq[i].size() < 2;
            if (mq[i].size() == 0 || (mov[i] && !ordy[i])) fire = 1'b0;
        end
        chk("rot", {30'd0, rot}, mrot);
`ifdef CAROUSEL_ROUND_COUNT_EN
        chk("round_count", {16'd0, rc}, {16'd0, mrc});
`endif
        for (int i = 0; i < 3; i++)
            if (mov[i] && ordy[i] && exq[i].size() != 0) void'(exq[i].pop_front());
        if (fire) begin
            for (int j = 0; j < 3; j++) exq[j].push_back(mq[(j + mrot) % 3][0]);
            for (int i = 0; i < 3; i++) void'(mq[i].pop_front());
            mrot = (mrot + 1) % 3;
            mov  = 3'b111;
            mrc  = mrc + 16'd1;
        end else begin
            mov = mov & ~ordy;
        end
        for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(d[i*8 +: 8]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.data_in = '0;
        bus.data_in_valid = '0;
        bus.data_out_ready = '0;
        #2;
        chk("rst_valid", {29'd0, bus.data_out_valid}, 32'd0);
        chk("rst_data", {8'd0, bus.data_out}, 32'd0);
        chk("rst_rot", {30'd0, rot}, 32'd0);
        chk("rst_ready", {29'd0, bus.data_in_ready}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {29'd0, bus.data_in_ready}, 32'd7);
    endtask

    task automatic run_table();
        for (int k = 0; k < 4; k++) begin
            cycle(tab[k].vin, tab[k].d, tab[k].ordy);
            chk($sformatf("tab%0d_valid", k), {29'd0, bus.data_out_valid}, {29'd0, tab[k].ov});
            chk($sformatf("tab%0d_rot", k), {30'd0, rot}, {30'd0, tab[k].rot});
            chk($sformatf("tab%0d_out", k), {8'd0, bus.data_out}, {8'd0, tab[k].out});
        end
    endtask

    initial begin
        tab[0] = '{3'b111, 24'h302010, 3'b111, 3'b000, 2'd0, 24'h000000};
        tab[1] = '{3'b111, 24'h312111, 3'b111, 3'b111, 2'd1, 24'h302010};
        tab[2] = '{3'b000, 24'h000000, 3'b111, 3'b111, 2'd2, 24'h113121};
        tab[3] = '{3'b000, 24'h000000, 3'b111, 3'b000, 2'd2, 24'h113121};

        do_reset();
        run_table();

        // starvation: ch2 silent, ch0/ch1 fill up and stall
        cycle(3'b011, 24'h005040, 3'b111);
        cycle(3'b011, 24'h005141, 3'b111);
        chk("starve_ready", {29'd0, bus.data_in_ready}, 32'd4);
        cycle(3'b011, 24'h005242, 3'b111);
        chk("starve_valid", {29'd0, bus.data_out_valid}, 32'd0);
        cycle(3'b100, 24'h600000, 3'b111);
        chk("starve_valid2", {29'd0, bus.data_out_valid}, 32'd0);
        cycle(3'b000, 24'h000000, 3'b111);
        chk("starve_round", {8'd0, bus.data_out}, 32'h504060);
        chk("starve_rot", {30'd0, rot}, 32'd0);

        // backpressure on lane 1
        cycle(3'b100, 24'h610000, 3'b101);
        chk("bp_valid", {29'd0, bus.data_out_valid}, 32'd2);
        for (int k = 0; k < 2; k++) begin
            cycle(3'b000, 24'h000000, 3'b101);
            chk("bp_stall_valid", {29'd0, bus.data_out_valid}, 32'd2);
            chk("bp_stall_rot", {30'd0, rot}, 32'd0);
            chk("bp_hold", {24'd0, bus.data_out[15:8]}, 32'h40);
        end
        cycle(3'b000, 24'h000000, 3'b111);
        chk("bp_round", {8'd0, bus.data_out}, 32'h615141);
        chk("bp_rot", {30'd0, rot}, 32'd1);
        cycle(3'b000, 24'h000000, 3'b111);
        chk("bp_drained", exq[0].size() + exq[1].size() + exq[2].size() + mq[0].size()
                          + mq[1].size() + mq[2].size(), 32'd0);

        // three back-to-back rounds return the offset to its start
        for (int k = 0; k < 4; k++) cycle(3'b111, 24'($urandom), 3'b111);
        chk("wrap_rot", {30'd0, rot}, 32'd1);
        cycle(3'b000, 24'h000000, 3'b111);
        cycle(3'b000, 24'h000000, 3'b111);
        chk("wrap_idle", {29'd0, bus.data_out_valid}, 32'd0);

`ifdef CAROUSEL_ROUND_COUNT_EN
        for (int k = 0; k < 65540; k++) cycle(3'b111, 24'($urandom), 3'b111);
        chk("rc_wrapped", {16'd0, rc}, {16'd0, mrc});
        cycle(3'b000, 24'h000000, 3'b111);
        cycle(3'b000, 24'h000000, 3'b111);
`endif

        // mid-operation reset with FIFOs full and lanes valid
        cycle(3'b111, 24'hA3A2A1, 3'b000);
        cycle(3'b111, 24'hB3B2B1, 3'b000);
        cycle(3'b111, 24'hC3C2C1, 3'b000);
        chk("full_ready", {29'd0, bus.data_in_ready}, 32'd0);
        chk("full_valid", {29'd0, bus.data_out_valid}, 32'd7);
        do_reset();
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
